// File: rtl/spislv_swc.sv
// APB-programmed SPI target with TX/RX FIFOs; sck/nss/mosi oversampled in pclk.
// Optional interrupt output enabled by defining SPISLV_IRQ_EN.
module spislv_swc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic         pclk,
    input  logic         prstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rp];

    always_ff @(posedge pclk) begin
        if (do_push) mem[wp] <= wdata;
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module spislv_swc #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0011_0000
) (
    input  logic        pclk,
    input  logic        prstn,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    input  logic        sck,
    input  logic        nss,
    input  logic        mosi,
    output logic        miso,
`ifdef SPISLV_IRQ_EN
    output logic        miso_oe,
    output logic        irq
`else
    output logic        miso_oe
`endif
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;
    state_t state_q, state_d;

    logic [2:0]  sck_s;
    logic [1:0]  nss_s, mosi_s;
    logic        nss_d;
    logic        cr_cpha, cr_cpol, cr_en, cr_lsbf, cr_dff;
`ifdef SPISLV_IRQ_EN
    logic        cr_rxneie, cr_txeie;
`endif
    logic        ovr, udr, bsy;
    logic [15:0] sho, shi, shi_next, rx_word, tx_word;
    logic [4:0]  bit_cnt;
    logic        tx_push, tx_pop, rx_push, rx_pop, tx_empty, tx_full, rx_empty, rx_full;
    logic [15:0] tx_rdata, rx_rdata;
    logic        acc, apb_err, cr_we, sr_clr, set_ovr, set_udr;
    logic [31:0] rd_val, cr_val, sr_val;
    logic        sck_rise, sck_fall, lead_e, trail_e, sample_e, shift_e, nss_fall, frame_done;
    logic        unused_pwdata;

    assign unused_pwdata = ^pwdata[31:16];

    function automatic logic first_bit(input logic [15:0] w, input logic lsbf, input logic dff);
        return lsbf ? w[0] : (dff ? w[15] : w[7]);
    endfunction

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            sck_s  <= '0;
            nss_s  <= '1;
            nss_d  <= 1'b1;
            mosi_s <= '0;
        end else begin
            sck_s  <= {sck_s[1:0], sck};
            nss_s  <= {nss_s[0], nss};
            nss_d  <= nss_s[1];
            mosi_s <= {mosi_s[0], mosi};
        end
    end

    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign sck_fall = ~sck_s[1] & sck_s[2];
    assign lead_e   = cr_cpol ? sck_fall : sck_rise;
    assign trail_e  = cr_cpol ? sck_rise : sck_fall;
    assign sample_e = cr_cpha ? trail_e : lead_e;
    assign shift_e  = cr_cpha ? lead_e : trail_e;
    assign nss_fall = ~nss_s[1] & nss_d;
    assign bsy      = cr_en & ~nss_s[1];

    assign shi_next   = cr_lsbf ? {mosi_s[1], shi[15:1]} : {shi[14:0], mosi_s[1]};
    assign rx_word    = cr_dff ? shi_next : (cr_lsbf ? {8'h00, shi_next[15:8]} : {8'h00, shi_next[7:0]});
    assign tx_word    = tx_empty ? '0 : tx_rdata;
    assign frame_done = (bit_cnt + 5'd1) == (cr_dff ? 5'd16 : 5'd8);

    always_comb begin
        cr_val     = '0;
        cr_val[0]  = cr_cpha;
        cr_val[1]  = cr_cpol;
        cr_val[6]  = cr_en;
        cr_val[7]  = cr_lsbf;
        cr_val[11] = cr_dff;
`ifdef SPISLV_IRQ_EN
        cr_val[12] = cr_rxneie;
        cr_val[13] = cr_txeie;
`endif
        sr_val = {23'h0, udr, bsy, ovr, 3'b000, tx_empty, ~tx_full, ~rx_empty};
    end

    assign acc = psel & penable & ~pready;

    always_comb begin
        rd_val  = '0;
        apb_err = 1'b0;
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        cr_we   = 1'b0;
        sr_clr  = 1'b0;
        if (acc) begin
            if (paddr == BASE_ADDR) begin
                if (!pwrite)  rd_val  = cr_val;
                else if (bsy) apb_err = 1'b1;
                else          cr_we   = 1'b1;
            end else if (paddr == BASE_ADDR + 32'h4) begin
                if (!pwrite) begin
                    rd_val = sr_val;
                    sr_clr = 1'b1;
                end
            end else if (paddr == BASE_ADDR + 32'h8) begin
                if (pwrite) begin
                    if (tx_full) apb_err = 1'b1;
                    else         tx_push = 1'b1;
                end
            end else if (paddr == BASE_ADDR + 32'hC) begin
                if (!pwrite && !rx_empty) begin
                    rd_val = {16'h0000, rx_rdata};
                    rx_pop = 1'b1;
                end
            end else begin
                apb_err = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            pready    <= 1'b0;
            prdata    <= '0;
            pslverr   <= 1'b0;
            cr_cpha   <= 1'b0;
            cr_cpol   <= 1'b0;
            cr_en     <= 1'b0;
            cr_lsbf   <= 1'b0;
            cr_dff    <= 1'b0;
`ifdef SPISLV_IRQ_EN
            cr_rxneie <= 1'b0;
            cr_txeie  <= 1'b0;
`endif
            ovr       <= 1'b0;
            udr       <= 1'b0;
        end else begin
            pready  <= acc;
            prdata  <= rd_val;
            pslverr <= apb_err;
            if (cr_we) begin
                cr_cpha   <= pwdata[0];
                cr_cpol   <= pwdata[1];
                cr_en     <= pwdata[6];
                cr_lsbf   <= pwdata[7];
                cr_dff    <= pwdata[11];
`ifdef SPISLV_IRQ_EN
                cr_rxneie <= pwdata[12];
                cr_txeie  <= pwdata[13];
`endif
            end
            // a new SPI-side event wins over a same-cycle SR read clear
            if (set_ovr)     ovr <= 1'b1;
            else if (sr_clr) ovr <= 1'b0;
            if (set_udr)     udr <= 1'b1;
            else if (sr_clr) udr <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        set_ovr = 1'b0;
        set_udr = 1'b0;
        case (state_q)
            ST_IDLE: if (cr_en && nss_fall) state_d = ST_LOAD;
            ST_LOAD: begin
                if (!cr_en || nss_s[1]) state_d = ST_IDLE;
                else begin
                    state_d = ST_SHIFT;
                    tx_pop  = ~tx_empty;
                    set_udr = tx_empty;
                end
            end
            ST_SHIFT: begin
                if (!cr_en || nss_s[1]) state_d = ST_IDLE;
                else if (sample_e && frame_done) begin
                    state_d = ST_LOAD;
                    rx_push = ~rx_full;
                    set_ovr = rx_full;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // shift edges only act once a bit has been sampled in this frame, which skips the
    // CPHA=1 first leading edge and the CPHA=0 trailing edge that follows a reload
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q <= ST_IDLE;
            sho     <= '0;
            shi     <= '0;
            bit_cnt <= '0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
        end else begin
            state_q <= state_d;
            miso_oe <= (state_d != ST_IDLE);
            if (state_d == ST_IDLE) begin
                miso <= 1'b0;
            end else if (state_q == ST_IDLE) begin
                miso <= first_bit(tx_word, cr_lsbf, cr_dff);
            end else if (state_q == ST_LOAD) begin
                sho     <= tx_word;
                miso    <= first_bit(tx_word, cr_lsbf, cr_dff);
                bit_cnt <= '0;
            end else begin
                if (sample_e) begin
                    shi     <= shi_next;
                    bit_cnt <= bit_cnt + 5'd1;
                end
                if (shift_e && bit_cnt != '0) begin
                    if (cr_lsbf) begin
                        sho  <= {1'b0, sho[15:1]};
                        miso <= sho[1];
                    end else begin
                        sho  <= {sho[14:0], 1'b0};
                        miso <= cr_dff ? sho[14] : sho[6];
                    end
                end
            end
        end
    end

    spislv_swc_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_txf (
        .pclk(pclk), .prstn(prstn), .push(tx_push), .pop(tx_pop),
        .wdata(pwdata[15:0]), .rdata(tx_rdata), .empty(tx_empty), .full(tx_full)
    );

    spislv_swc_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_rxf (
        .pclk(pclk), .prstn(prstn), .push(rx_push), .pop(rx_pop),
        .wdata(rx_word), .rdata(rx_rdata), .empty(rx_empty), .full(rx_full)
    );

`ifdef SPISLV_IRQ_EN
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) irq <= 1'b0;
        else        irq <= (cr_rxneie & ~rx_empty) | (cr_txeie & tx_empty) | ovr | udr;
    end
`endif
endmodule

// File: tb/tb_spislv_swc.sv
// Directed bench for spislv_swc: APB register vector table plus SPI frame sequences.
module tb_spislv_swc;
    localparam logic [31:0] BASE = 32'h0011_0000;
    localparam logic [31:0] CR   = BASE;
    localparam logic [31:0] SR   = BASE + 32'h4;
    localparam logic [31:0] TDR  = BASE + 32'h8;
    localparam logic [31:0] RDR  = BASE + 32'hC;

    logic        pclk = 1'b0, prstn = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0, prdata;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pready, pslverr;
    logic        sck = 1'b0, nss = 1'b1, mosi = 1'b0, miso, miso_oe;

    int checks = 0;
    int failures = 0;

    spislv_swc #(.FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
        .pclk(pclk), .prstn(prstn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .sck(sck), .nss(nss), .mosi(mosi), .miso(miso),
        .miso_oe(miso_oe)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        int n;
        tick(1);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        tick(1);
        penable = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!pready && n < 8);
        chk("apb_pready", 32'(pready), 32'd1);
        rd = prdata;
        err = pslverr;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        tick(1);
        chk("apb_pready_pulse", 32'(pready), 32'd0);
    endtask

    task automatic wr_reg(input string name, input logic [31:0] addr, input logic [31:0] d,
                          input logic exp_err);
        logic [31:0] rd;
        logic err;
        apb(1'b1, addr, d, rd, err);
        chk({name, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic rd_reg(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic err;
        apb(1'b0, addr, '0, rd, err);
        chk(name, rd, exp);
        chk({name, "_err"}, 32'(err), 32'd0);
    endtask

    // controller model: sck half period 4 pclk, w-bit word, n bits clocked
    task automatic spi_xfer(input logic [15:0] mo, input int w, input int n,
                            input logic cpol, input logic cpha, input logic lsbf,
                            input logic keep, output logic [15:0] mi);
        int idx;
        mi = '0;
        if (nss) begin
            nss = 1'b0;
            if (cpha) tick(4);
        end
        for (int i = 0; i < n; i++) begin
            idx = lsbf ? i : w - 1 - i;
            if (!cpha) begin
                mosi = mo[idx];
                tick(4);
                mi[idx] = miso;
                sck = ~cpol;
                tick(4);
                sck = cpol;
            end else begin
                sck = ~cpol;
                mosi = mo[idx];
                tick(4);
                mi[idx] = miso;
                sck = cpol;
                tick(4);
            end
        end
        if (!keep) begin
            tick(4);
            nss = 1'b1;
            tick(8);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [15:0] mi;
        logic [15:0] mo5 [5];
        logic [15:0] ex5 [5];

        tbl[0]  = '{wr: 1'b0, addr: CR,             wd: 32'h0,         exp_rd: 32'h0,   exp_err: 1'b0};
        tbl[1]  = '{wr: 1'b0, addr: SR,             wd: 32'h0,         exp_rd: 32'h6,   exp_err: 1'b0};
        tbl[2]  = '{wr: 1'b0, addr: RDR,            wd: 32'h0,         exp_rd: 32'h0,   exp_err: 1'b0};
        tbl[3]  = '{wr: 1'b0, addr: TDR,            wd: 32'h0,         exp_rd: 32'h0,   exp_err: 1'b0};
        tbl[4]  = '{wr: 1'b1, addr: BASE + 32'h10,  wd: 32'h1234,      exp_rd: 32'h0,   exp_err: 1'b1};
        tbl[5]  = '{wr: 1'b0, addr: BASE + 32'h10,  wd: 32'h0,         exp_rd: 32'h0,   exp_err: 1'b1};
        tbl[6]  = '{wr: 1'b1, addr: CR,             wd: 32'hFFFF_FFFF, exp_rd: 32'h0,   exp_err: 1'b0};
        tbl[7]  = '{wr: 1'b0, addr: CR,             wd: 32'h0,         exp_rd: 32'h8C3, exp_err: 1'b0};
        tbl[8]  = '{wr: 1'b1, addr: CR,             wd: 32'h0,         exp_rd: 32'h0,   exp_err: 1'b0};
        tbl[9]  = '{wr: 1'b1, addr: RDR,            wd: 32'h55,        exp_rd: 32'h0,   exp_err: 1'b0};
        tbl[10] = '{wr: 1'b1, addr: SR,             wd: 32'hFFFF,      exp_rd: 32'h0,   exp_err: 1'b0};
        tbl[11] = '{wr: 1'b0, addr: SR,             wd: 32'h0,         exp_rd: 32'h6,   exp_err: 1'b0};
        tbl[12] = '{wr: 1'b0, addr: CR,             wd: 32'h0,         exp_rd: 32'h0,   exp_err: 1'b0};

        tick(3);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        prstn = 1'b1;
        tick(2);

        for (int i = 0; i < 13; i++) begin
            apb(tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, err);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
        end

        // mode 0, MSB-first, 8-bit; trailing reload after the frame underruns
        wr_reg("m0_cr", CR, 32'h40, 1'b0);
        wr_reg("m0_tdr", TDR, 32'hA5, 1'b0);
        rd_reg("m0_sr_pre", SR, 32'h2);
        spi_xfer(16'h003C, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, mi);
        chk("m0_miso", 32'(mi), 32'hA5);
        rd_reg("m0_sr_rxne", SR, 32'h107);
        rd_reg("m0_rdr", RDR, 32'h3C);
        rd_reg("m0_sr_post", SR, 32'h6);

        // mode 3, LSB-first, 16-bit
        sck = 1'b1;
        tick(2);
        wr_reg("m3_cr", CR, 32'h08C3, 1'b0);
        wr_reg("m3_tdr", TDR, 32'h1234, 1'b0);
        spi_xfer(16'hBEEF, 16, 16, 1'b1, 1'b1, 1'b1, 1'b0, mi);
        chk("m3_miso", 32'(mi), 32'h1234);
        rd_reg("m3_rdr", RDR, 32'hBEEF);
        rd_reg("m3_sr", SR, 32'h106);

        // five back-to-back frames into a 4-deep RX FIFO, TX runs dry on the fifth
        wr_reg("ovr_cr", CR, 32'h40, 1'b0);
        sck = 1'b0;
        tick(2);
        wr_reg("ovr_tdr0", TDR, 32'h11, 1'b0);
        wr_reg("ovr_tdr1", TDR, 32'h22, 1'b0);
        wr_reg("ovr_tdr2", TDR, 32'h33, 1'b0);
        wr_reg("ovr_tdr3", TDR, 32'h44, 1'b0);
        wr_reg("ovr_tdr_full", TDR, 32'h55, 1'b1);
        mo5 = '{16'h81, 16'h42, 16'h24, 16'h18, 16'hFF};
        ex5 = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h00};
        for (int i = 0; i < 5; i++) begin
            spi_xfer(mo5[i], 8, 8, 1'b0, 1'b0, 1'b0, (i < 4) ? 1'b1 : 1'b0, mi);
            chk($sformatf("ovr_miso%0d", i), 32'(mi), 32'(ex5[i]));
        end
        rd_reg("ovr_sr_set", SR, 32'h147);
        rd_reg("ovr_sr_clr", SR, 32'h007);
        for (int i = 0; i < 4; i++) rd_reg($sformatf("ovr_rdr%0d", i), RDR, 32'(mo5[i]));
        rd_reg("ovr_sr_empty", SR, 32'h6);

        // abort after 5 bits, then a clean frame
        wr_reg("abt_tdr", TDR, 32'h5A, 1'b0);
        spi_xfer(16'h00FF, 8, 5, 1'b0, 1'b0, 1'b0, 1'b0, mi);
        chk("abt_miso", 32'(mi), 32'h58);
        rd_reg("abt_sr", SR, 32'h6);
        wr_reg("abt_tdr2", TDR, 32'hC3, 1'b0);
        spi_xfer(16'h0096, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, mi);
        chk("abt_miso2", 32'(mi), 32'hC3);
        rd_reg("abt_rdr", RDR, 32'h96);
        rd_reg("abt_sr2", SR, 32'h106);

        // CR write while selected is rejected
        nss = 1'b0;
        tick(4);
        rd_reg("bsy_sr", SR, 32'h186);
        chk("bsy_miso_oe", 32'(miso_oe), 32'd1);
        wr_reg("bsy_cr", CR, 32'h0, 1'b1);
        nss = 1'b1;
        tick(8);
        chk("idle_miso_oe", 32'(miso_oe), 32'd0);
        rd_reg("bsy_cr_kept", CR, 32'h40);
        rd_reg("bsy_sr_idle", SR, 32'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spislv_swc.md
# spislv_swc

APB-programmed SPI target (slave) peripheral for the SwitchMCU peripheral bus: it is the responder at the far end of an SPI link driven by an external controller. It oversamples the incoming sck/nss/mosi lines in the pclk domain, shifts received words into an RX FIFO and returns TX FIFO words on miso. Register layout and control-bit positions match the SPI controller block so firmware can share drivers.

## Interface
- FIFO_DEPTH, 4: entries in each of the TX and RX FIFOs; power of two, at least 2.
- BASE_ADDR, 'h0011_0000: base of the 4-register window.
- pclk  input  1  single clock for bus and SPI logic.
- prstn  input  1  reset. **Asynchronous, active-low.**
- paddr  input  32  APB address.
- psel, penable, pwrite  input  1 each  APB control.
- pwdata  input  32  APB write data.
- pready  output  1  APB ready (registered).
- prdata  output  32  APB read data (registered).
- pslverr  output  1  APB error, valid with pready.
- sck  input  1  SPI clock from the controller (asynchronous).
- nss  input  1  active-low select (asynchronous).
- mosi  input  1  controller-to-target data.
- miso  output  1  target-to-controller data.
- miso_oe  output  1  pad enable for miso; 1 while selected and enabled.
- irq  output  1  interrupt; exists only with SPISLV_IRQ_EN.

## Operation
- Registers (offset from BASE_ADDR):
  - CR +0x0, R/W: [0] CPHA, [1] CPOL, [6] EN, [7] LSBFIRST, [11] DFF (1 = 16-bit, 0 = 8-bit), [12] RXNEIE, [13] TXEIE. Other bits read 0.
  - SR +0x4, RO: [0] RXNE, [1] TXNF (TX not full), [2] TXE (TX empty), [6] OVR sticky, [7] BSY (EN & synchronized nss low), [8] UDR sticky. A read of SR clears OVR and UDR in the completion cycle.
  - TDR +0x8: a write pushes pwdata[15:0] (low 8 bits used when DFF=0). A write while the FIFO is full is dropped and pslverr=1. Reads return 0.
  - RDR +0xC: a read pops the RX head and returns it zero-extended. A read while the FIFO is empty returns 0 with no error. Writes are ignored.
  - Any other address: pslverr=1, no side effect, prdata=0.
- CR is written only while BSY=0. A CR write while BSY=1 is dropped with pslverr=1.
- Synchronizers: sck, nss and mosi each pass through 2 flops. sck edges are detected on the synchronized value against a 3rd flop.
- Leading edge = idle-to-active transition of sck (idle level = CPOL). Sample edge: leading edge when CPHA=0, trailing edge when CPHA=1. The shift edge is the other edge.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: miso=0, miso_oe=0. Move to LOAD on EN=1 and synchronized nss falling.
  - LOAD (1 cycle): pop the TX head into the shift-out register. If TX is empty, load 0 and set UDR. Clear the bit counter. Then go to SHIFT.
  - SHIFT: each sample edge shifts mosi into the shift-in register (MSB-first, or LSB-first per LSBFIRST) and increments the bit counter.
    - Each shift edge advances miso to the next bit. The first shift edge of a frame is skipped when CPHA=1; in that mode the first bit is presented on the first leading edge.
    - When the counter reaches 8 or 16 (DFF): push the received word into RX. If RX is full, drop the word and set OVR. Then go to LOAD if nss is still low, else IDLE.
- nss rising (synchronized) or EN cleared in SHIFT/LOAD aborts the frame: partial RX data is discarded, no push, back to IDLE next cycle.
- Simultaneous APB RDR pop and SPI RX push in one cycle: both take effect, and the count is unchanged when the FIFO is neither full nor empty. The same rule applies to a TX push and LOAD pop in one cycle.

## Timing
- APB: one wait state. pready=1 for exactly one cycle, in the cycle after the first psel&penable cycle. Register updates, FIFO push/pop, prdata and pslverr all take effect in that cycle. pready is 0 otherwise.
- Reset values: pready=0, prdata=0, pslverr=0, miso=0, miso_oe=0, irq=0, CR=0, OVR=UDR=0, FIFOs empty, FSM=IDLE.
- The sck high and low phases must each be at least 4 pclk cycles. nss setup to the first sck edge must be at least 4 pclk cycles.
- miso changes 3 pclk cycles after the causing sck edge or nss fall (sync + edge detect), and is registered.
- The RX word is visible in SR.RXNE 1 cycle after the push.

## Configuration
- SPISLV_IRQ_EN defined: port irq exists, registered. irq = (RXNEIE & RXNE) | (TXEIE & TXE) | OVR | UDR.
- SPISLV_IRQ_EN undefined: no irq port. CR[13:12] read as 0 and ignore writes.

## Test plan
- Reset, then read CR, SR and RDR:
  - CR=0; SR=0x0000_0006 (TXNF=1, TXE=1); RDR=0; pslverr=0.
- CR=0x0040 (mode 0, MSB-first, 8-bit); TDR=0xA5; controller sends 0x3C with sck=pclk/8:
  - miso bit stream is 1010_0101.
  - RDR reads 0x3C.
  - SR.RXNE goes 1 then 0 after the read.
- CR=0x08C3 (CPOL=1, CPHA=1, LSB-first, 16-bit); TDR=0x1234; controller sends 0xBEEF:
  - miso LSB-first stream is 0x1234.
  - RDR reads 0xBEEF.
- Five back-to-back 8-bit frames with nss held low, no RDR reads, FIFO_DEPTH=4:
  - First 4 words are stored and the 5th is dropped; SR.OVR=1.
  - After an SR read, SR.OVR=0.
- Frame started with TX empty: miso is all zeros and SR.UDR=1.
- nss raised after 5 bits: RXNE stays 0 and BSY=0.
- Write paddr=BASE_ADDR+0x10: pslverr=1 with pready. Write CR while BSY=1: pslverr=1 and CR is unchanged.
